// File: rtl/ctrl_ws.sv
// Multi-cycle SISC control FSM with early exit for branches/NOOP and a memory ready handshake.
// Optional memory timeout into HALT is compiled in with `define CTRL_TIMEOUT_EN.
module ctrl_ws #(
  parameter int unsigned FLAG_W   = 4,
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned WAIT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [3:0]        opcode,
  input  logic [FLAG_W-1:0] mm,
  input  logic [FLAG_W-1:0] stat,
  input  logic              mem_rdy,
  output logic              mem_req,
  output logic              dm_we,
  output logic              ir_load,
  output logic              pc_write,
  output logic              pc_sel,
  output logic              br_sel,
  output logic              pc_rst,
  output logic              rf_we,
  output logic              wb_sel,
  output logic              rb_sel,
  output logic [1:0]        alu_op,
  output logic              halted,
  output logic              err
);

  localparam logic [3:0] OpNoop = 4'd0;
  localparam logic [3:0] OpLod  = 4'd1;
  localparam logic [3:0] OpStr  = 4'd2;
  localparam logic [3:0] OpBra  = 4'd4;
  localparam logic [3:0] OpBrr  = 4'd5;
  localparam logic [3:0] OpBne  = 4'd6;
  localparam logic [3:0] OpBnr  = 4'd7;
  localparam logic [3:0] OpAlu  = 4'd8;
  localparam logic [3:0] OpHlt  = 4'd15;

  typedef enum logic [2:0] {
    StStart0, StStart1, StFetch, StDecode, StExecute, StMem, StWriteback, StHalt
  } state_e;

  state_e r_state, w_state_next;
  logic   r_err, w_err_set;
  logic   w_mask_zero, w_alu_imm, w_timeout;

  assign w_mask_zero = ~|(stat & mm);
  assign w_alu_imm   = (mm == FLAG_W'(8));

`ifdef CTRL_TIMEOUT_EN
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic              w_waiting;

  assign w_waiting = ((r_state == StFetch) || (r_state == StMem)) && !mem_rdy;
  assign w_timeout = w_waiting && (r_wait_cnt == WAIT_W'(WAIT_MAX - 1));

  // Any cycle that is not a continuing wait leaves the counter at zero.
  always_comb begin
    w_wait_cnt_next = '0;
    if (w_waiting && !w_timeout) w_wait_cnt_next = r_wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_f) r_wait_cnt <= '0;
    else        r_wait_cnt <= w_wait_cnt_next;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{WAIT_MAX[0], WAIT_W[0]};
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      r_state <= StStart0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    mem_req      = 1'b0;
    dm_we        = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    br_sel       = 1'b0;
    pc_rst       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    rb_sel       = 1'b0;
    alu_op       = 2'b10;
    halted       = 1'b0;
    err          = r_err;

    unique case (r_state)
      StStart0: begin
        pc_rst       = 1'b1;
        w_state_next = StStart1;
      end
      StStart1: begin
        pc_rst       = 1'b1;
        w_state_next = StFetch;
      end
      StFetch: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          ir_load      = 1'b1;
          pc_write     = 1'b1;
          w_state_next = StDecode;
        end else if (w_timeout) begin
          w_state_next = StHalt;
          w_err_set    = 1'b1;
        end
      end
      StDecode: begin
        case (opcode)
          OpNoop: w_state_next = StFetch;
          OpBra, OpBrr, OpBne, OpBnr: begin
            w_state_next = StFetch;
            // BNE/BNR branch on a clear masked status, BRA/BRR on a set one.
            if (((opcode == OpBne) || (opcode == OpBnr)) ? w_mask_zero : !w_mask_zero) begin
              pc_write = 1'b1;
              pc_sel   = 1'b1;
              br_sel   = (opcode == OpBra) || (opcode == OpBne);
            end
          end
          OpLod, OpStr, OpAlu: w_state_next = StExecute;
          OpHlt: w_state_next = StHalt;
          default: begin
            w_state_next = StHalt;
            w_err_set    = 1'b1;
          end
        endcase
      end
      StExecute: begin
        if (opcode == OpAlu) begin
          alu_op       = w_alu_imm ? 2'b01 : 2'b00;
          w_state_next = StWriteback;
        end else begin
          alu_op       = 2'b01;
          w_state_next = StMem;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        alu_op  = 2'b01;
        dm_we   = (opcode == OpStr);
        if (mem_rdy) begin
          w_state_next = (opcode == OpStr) ? StFetch : StWriteback;
        end else if (w_timeout) begin
          w_state_next = StHalt;
          w_err_set    = 1'b1;
        end
      end
      StWriteback: begin
        rf_we        = 1'b1;
        rb_sel       = 1'b1;
        w_state_next = StFetch;
        if (opcode == OpAlu) alu_op = w_alu_imm ? 2'b01 : 2'b00;
        else                 wb_sel = 1'b1;
      end
      StHalt: halted = 1'b1;
    endcase

    // Reset is synchronous, so the present state may be stale while rst_f is low.
    if (!rst_f) begin
      mem_req  = 1'b0;
      dm_we    = 1'b0;
      ir_load  = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      pc_rst   = 1'b1;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      rb_sel   = 1'b0;
      alu_op   = 2'b10;
      halted   = 1'b0;
      err      = 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_ws.sv
// Self-checking bench for ctrl_ws: directed literal checks, then randomized traffic against an
// instruction-level reference model. Honours CTRL_TIMEOUT_EN like the design.
module tb_ctrl_ws;

  localparam int WaitMax = 16;

  logic       clk, rst_f, mem_rdy;
  logic [3:0] opcode, mm, stat;
  logic       mem_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst;
  logic       rf_we, wb_sel, rb_sel, halted, err;
  logic [1:0] alu_op;

  int n_chk = 0;
  int n_err = 0;

  ctrl_ws #(.FLAG_W(4), .WAIT_MAX(WaitMax), .WAIT_W(5)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .dm_we(dm_we), .ir_load(ir_load), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .pc_rst(pc_rst), .rf_we(rf_we), .wb_sel(wb_sel),
    .rb_sel(rb_sel), .alu_op(alu_op), .halted(halted), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output vector: mem_req dm_we ir_load pc_write pc_sel br_sel pc_rst rf_we wb_sel rb_sel
  // alu_op[1:0] halted err
  typedef enum int {PFetch, PDecode, PExec, PMem, PWb} phase_e;
  phase_e m_plan[$];
  int     m_boot = 0;
  int     m_wait = 0;
  bit     m_halt = 1'b0;
  bit     m_err  = 1'b0;

  // Instruction-level reference: each instruction is a list of phases; wait phases retire only
  // on mem_rdy. Updates the model for the next cycle as a side effect.
  task automatic model_step(input bit rst, input logic [3:0] op, input logic [3:0] mmv,
                            input logic [3:0] st, input bit rdy, output logic [13:0] want);
    phase_e ph;
    bit     done, taken;
    want      = '0;
    want[3:2] = 2'b10;
    if (!rst) begin
      want[7] = 1'b1;
      m_boot = 2; m_halt = 1'b0; m_err = 1'b0; m_wait = 0;
      m_plan.delete();
      return;
    end
    if (m_boot > 0) begin
      want[7] = 1'b1;
      m_boot--;
      if (m_boot == 0) m_plan.push_back(PFetch);
      return;
    end
    if (m_halt) begin
      want[1] = 1'b1;
      want[0] = m_err;
      return;
    end
    ph   = m_plan[0];
    done = 1'b1;
    case (ph)
      PFetch: begin
        want[13] = 1'b1;
        if (rdy) begin want[11] = 1'b1; want[10] = 1'b1; end
        else done = 1'b0;
      end
      PDecode: begin
        if (op inside {4'd4, 4'd5, 4'd6, 4'd7}) begin
          taken = (op >= 4'd6) ? ((st & mmv) == 4'd0) : ((st & mmv) != 4'd0);
          if (taken) begin
            want[10] = 1'b1; want[9] = 1'b1;
            want[8]  = (op == 4'd4) || (op == 4'd6);
          end
        end
      end
      PExec: want[3:2] = (op == 4'd8 && mmv != 4'd8) ? 2'b00 : 2'b01;
      PMem: begin
        want[13]  = 1'b1;
        want[12]  = (op == 4'd2);
        want[3:2] = 2'b01;
        if (!rdy) done = 1'b0;
      end
      PWb: begin
        want[6] = 1'b1;
        want[4] = 1'b1;
        if (op == 4'd8) want[3:2] = (mmv == 4'd8) ? 2'b01 : 2'b00;
        else            want[5]   = 1'b1;
      end
      default: ;
    endcase
    if (!done) begin
`ifdef CTRL_TIMEOUT_EN
      if (m_wait == WaitMax - 1) begin m_halt = 1'b1; m_err = 1'b1; end
      else m_wait++;
`endif
      return;
    end
    m_wait = 0;
    void'(m_plan.pop_front());
    if (ph == PFetch) m_plan.push_back(PDecode);
    if (ph == PDecode) begin
      case (op)
        4'd0, 4'd4, 4'd5, 4'd6, 4'd7: ;
        4'd8:    begin m_plan.push_back(PExec); m_plan.push_back(PWb); end
        4'd1:    begin m_plan.push_back(PExec); m_plan.push_back(PMem); m_plan.push_back(PWb); end
        4'd2:    begin m_plan.push_back(PExec); m_plan.push_back(PMem); end
        4'd15:   m_halt = 1'b1;
        default: begin m_halt = 1'b1; m_err = 1'b1; end
      endcase
    end
    if (m_plan.size() == 0) m_plan.push_back(PFetch);
  endtask

  task automatic check(input string nm, input logic [13:0] got, input logic [13:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %014b want %014b", nm, $time, got, want);
    end
  endtask

  // One clock: drive inputs, sample mid-cycle, compare against model (and literal if given).
  task automatic tick(input bit rst, input logic [3:0] op, input logic [3:0] mmv,
                      input logic [3:0] st, input bit rdy, input bit lit_en,
                      input logic [13:0] lit, input string nm);
    logic [13:0] got, want;
    rst_f = rst; opcode = op; mm = mmv; stat = st; mem_rdy = rdy;
    #2;
    got = {mem_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, rf_we, wb_sel, rb_sel,
           alu_op, halted, err};
    model_step(rst, op, mmv, st, rdy, want);
    check({nm, "/model"}, got, want);
    if (lit_en) check(nm, got, lit);
    @(posedge clk);
    #1;
  endtask

  task automatic d(input bit rst, input logic [3:0] op, input logic [3:0] mmv,
                   input logic [3:0] st, input bit rdy, input logic [13:0] lit, input string nm);
    tick(rst, op, mmv, st, rdy, 1'b1, lit, nm);
  endtask

  initial begin
    logic [3:0] r_op, r_mm;
    logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    bit         r_rst, can_change;
    int         hold;
    rst_f = 1'b0; opcode = '0; mm = '0; stat = '0; mem_rdy = 1'b0;
    @(posedge clk);
    #1;

    d(0, 8, 8, 0, 1, 14'h0088, "in_reset");
    d(0, 8, 8, 0, 1, 14'h0088, "in_reset");
    d(1, 8, 8, 0, 1, 14'h0088, "start0");
    d(1, 8, 8, 0, 1, 14'h0088, "start1");
    d(1, 8, 8, 0, 1, 14'h2C08, "fetch_alu_imm");
    d(1, 8, 8, 0, 1, 14'h0008, "dec_alu_imm");
    d(1, 8, 8, 0, 1, 14'h0004, "exe_alu_imm");
    d(1, 8, 8, 0, 1, 14'h0054, "wb_alu_imm");
    d(1, 8, 0, 0, 1, 14'h2C08, "fetch_alu_reg");
    d(1, 8, 0, 0, 1, 14'h0008, "dec_alu_reg");
    d(1, 8, 0, 0, 1, 14'h0000, "exe_alu_reg");
    d(1, 8, 0, 0, 1, 14'h0050, "wb_alu_reg");
    d(1, 6, 2, 1, 1, 14'h2C08, "fetch_bne");
    d(1, 6, 2, 1, 1, 14'h0708, "bne_taken");
    d(1, 6, 2, 2, 1, 14'h2C08, "fetch_bne2");
    d(1, 6, 2, 2, 1, 14'h0008, "bne_not_taken");
    d(1, 1, 0, 0, 1, 14'h2C08, "fetch_lod");
    d(1, 1, 0, 0, 1, 14'h0008, "dec_lod");
    d(1, 1, 0, 0, 1, 14'h0004, "exe_lod");
    for (int i = 0; i < 3; i++) d(1, 1, 0, 0, 0, 14'h2004, "mem_lod_wait");
    d(1, 1, 0, 0, 1, 14'h2004, "mem_lod_done");
    d(1, 1, 0, 0, 1, 14'h0078, "wb_lod");
    d(1, 2, 0, 0, 1, 14'h2C08, "fetch_str");
    d(1, 2, 0, 0, 1, 14'h0008, "dec_str");
    d(1, 2, 0, 0, 1, 14'h0004, "exe_str");
    for (int i = 0; i < 3; i++) d(1, 2, 0, 0, 0, 14'h3004, "mem_str_wait");
    d(1, 2, 0, 0, 1, 14'h3004, "mem_str_done");
    d(1, 3, 0, 0, 1, 14'h2C08, "fetch_after_str");
    d(1, 3, 0, 0, 1, 14'h0008, "dec_swp");
    for (int i = 0; i < 3; i++) d(1, 3, 0, 0, 1, 14'h000B, "halt_illegal");
    d(0, 3, 0, 0, 1, 14'h0088, "rst_pulse");
    d(1, 15, 0, 0, 1, 14'h0088, "start0_again");
    d(1, 15, 0, 0, 1, 14'h0088, "start1_again");
    d(1, 15, 0, 0, 1, 14'h2C08, "fetch_hlt");
    d(1, 15, 0, 0, 1, 14'h0008, "dec_hlt");
    for (int i = 0; i < 2; i++) d(1, 15, 0, 0, 1, 14'h000A, "halt_clean");
    d(0, 0, 0, 0, 1, 14'h0088, "rst_pulse2");
    d(1, 0, 0, 0, 0, 14'h0088, "start0_tmo");
    d(1, 0, 0, 0, 0, 14'h0088, "start1_tmo");
`ifdef CTRL_TIMEOUT_EN
    for (int i = 0; i < WaitMax; i++) d(1, 0, 0, 0, 0, 14'h2008, "fetch_wait");
    d(1, 0, 0, 0, 0, 14'h000B, "timeout_halt");
`else
    for (int i = 0; i < 100; i++) d(1, 0, 0, 0, 0, 14'h2008, "fetch_wait");
    d(1, 0, 0, 0, 0, 14'h2008, "no_timeout");
`endif
    d(0, 0, 0, 0, 0, 14'h0088, "rst_pulse3");

    hold = 0;
    r_op = 4'd0;
    r_mm = 4'd0;
    for (int c = 0; c < 4000; c++) begin
      if (m_halt) hold++;
      r_rst = !((m_halt && hold > 3) || ($urandom_range(0, 299) == 0));
      if (!r_rst) hold = 0;
      // The IR fields may only change while no instruction is in flight.
      can_change = m_halt || (m_boot > 0) || (m_plan.size() == 0) || (m_plan[0] == PFetch);
      if (can_change) begin
        if ($urandom_range(0, 19) == 0) r_op = 4'($urandom_range(0, 15));
        else                            r_op = ops[$urandom_range(0, 7)];
        r_mm = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      end
      tick(r_rst, r_op, r_mm, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           1'b0, 14'h0, "random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
